// File: rtl/delta_planner.sv
// delta_planner: splits a requested target position into bounded
// step commands for the ladder delta counter, with a step budget.
module delta_planner #(
    parameter int POS_W      = 4,
    parameter int STEP_W     = 3,
    parameter int MAX_STEP   = 7,
    parameter int SETTLE     = 2,
    parameter int STEP_LIMIT = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [POS_W-1:0]  tgt,
    input  logic [POS_W-1:0]  current,
    output logic              step_valid,
    input  logic              step_ready,
    output logic [STEP_W-1:0] delta,
    output logic              direction,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(STEP_LIMIT + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [POS_W:0]  MAXS  = (POS_W+1)'(MAX_STEP);
    localparam logic [CW-1:0]   LIMIT = CW'(STEP_LIMIT);
    localparam logic [SW-1:0]   SLOAD = SW'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_STEP,
        S_SETTLE,
        S_FIN
    } state_t;

    state_t              state, state_d;
    logic [POS_W-1:0]    tgt_q, tgt_q_d;
    logic [CW-1:0]       step_cnt, step_cnt_d;
    logic [SW-1:0]       settle_cnt, settle_cnt_d;
    logic                step_valid_d;
    logic [STEP_W-1:0]   delta_d;
    logic                direction_d;
    logic                busy_d;
    logic                done_d;
    logic                err_d;

    logic                up;
    logic [POS_W:0]      diff;
    logic [POS_W:0]      dmin;

    // Distance to target, widened one bit so it never wraps.
    always_comb begin
        up   = tgt_q > current;
        diff = up ? ({1'b0, tgt_q} - {1'b0, current})
                  : ({1'b0, current} - {1'b0, tgt_q});
        dmin = (diff > MAXS) ? MAXS : diff;
    end

    // Only IDLE can take a new target.
    assign tgt_ready = (state == S_IDLE);

    // Next-state and next registered-output decode.
    always_comb begin
        state_d      = state;
        tgt_q_d      = tgt_q;
        step_cnt_d   = step_cnt;
        settle_cnt_d = settle_cnt;
        step_valid_d = step_valid;
        delta_d      = delta;
        direction_d  = direction;
        busy_d       = busy;
        done_d       = 1'b0;
        err_d        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (tgt_valid) begin
                    tgt_q_d    = tgt;
                    step_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                if (diff == '0) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else if (step_cnt == LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    delta_d      = STEP_W'(dmin);
                    direction_d  = up;
                    step_valid_d = 1'b1;
                    state_d      = S_STEP;
                end
            end
            S_STEP: begin
                if (step_ready) begin
                    step_valid_d = 1'b0;
                    delta_d      = '0;
                    step_cnt_d   = step_cnt + 1'b1;
                    settle_cnt_d = SLOAD;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_cnt_d = settle_cnt - 1'b1;
                if (settle_cnt == SW'(1)) begin
                    state_d = S_CALC;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= S_IDLE;
            tgt_q      <= '0;
            step_cnt   <= '0;
            settle_cnt <= '0;
            step_valid <= 1'b0;
            delta      <= '0;
            direction  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            tgt_q      <= tgt_q_d;
            step_cnt   <= step_cnt_d;
            settle_cnt <= settle_cnt_d;
            step_valid <= step_valid_d;
            delta      <= delta_d;
            direction  <= direction_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_delta_planner.sv
// tb_delta_planner: scoreboard bench with a behavioural counter model
// and a plan model computed from the move rules.
module tb_delta_planner;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] tgt = '0;
    logic [3:0] current = '0;
    logic       step_valid;
    logic       step_ready = 1'b0;
    logic [2:0] delta;
    logic       direction;
    logic       busy;
    logic       done;
    logic       err;

    delta_planner dut (
        .clk(clk), .resetn(resetn),
        .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt(tgt),
        .current(current),
        .step_valid(step_valid), .step_ready(step_ready),
        .delta(delta), .direction(direction),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_STEP = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] d;
        logic       up;
    } ev_t;

    ev_t        q[$];
    int         checks = 0;
    int         errors = 0;
    int         cmode = 0;
    int         rmode = 2;
    logic [3:0] cur_t = '0;

    task automatic chk(input bit ok, input string name,
                       input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Counter behaviour: 0 exact, 1 frozen, 2 overshoots by one.
    function automatic logic [3:0] nxt(input logic [3:0] c,
                                       input logic [2:0] d,
                                       input logic u, input int mode);
        int v;
        v = int'(c);
        if (mode == 0) v = u ? v + int'(d) : v - int'(d);
        else if (mode == 2) v = u ? v + int'(d) + 1 : v - int'(d) - 1;
        if (v > 15) v = 15;
        if (v < 0) v = 0;
        return 4'(v);
    endfunction

    // Whole-move prediction from the planning rules.
    task automatic plan(input logic [3:0] c0, input logic [3:0] t,
                        input int mode);
        logic [3:0] c;
        int dd;
        ev_t e;
        c = c0;
        for (int n = 0; n <= 15; n++) begin
            dd = (t > c) ? int'(t) - int'(c) : int'(c) - int'(t);
            if (dd == 0) begin
                e = '{K_DONE, 3'd0, 1'b0};
                q.push_back(e);
                return;
            end
            if (n == 15) begin
                e = '{K_ERR, 3'd0, 1'b0};
                q.push_back(e);
                return;
            end
            e = '{K_STEP, 3'((dd > 7) ? 7 : dd), t > c};
            q.push_back(e);
            c = nxt(c, e.d, e.up, mode);
        end
    endtask

    task automatic expect_ev(input ev_t got);
        ev_t e;
        if (q.size() == 0) begin
            chk(1'b0, "unexpected_event", int'(got), -1);
        end else begin
            e = q.pop_front();
            chk(e == got, "event", int'(got), int'(e));
        end
    endtask

    // Counter model: applies accepted steps, drives step_ready.
    initial begin
        logic hs, su;
        logic [2:0] sd;
        forever begin
            @(negedge clk);
            hs = step_valid && step_ready && !resetn;
            sd = delta;
            su = direction;
            @(posedge clk);
            #1;
            if (hs) current = nxt(current, sd, su, cmode);
            if (rmode == 0) step_ready = ($urandom_range(0, 3) != 0);
            else step_ready = (rmode == 2);
        end
    end

    // Monitor: output invariants and scoreboard pops.
    initial begin
        logic hold, hdir;
        logic [2:0] hd;
        ev_t g;
        hold = 1'b0;
        hd = '0;
        hdir = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                hold = 1'b0;
            end else begin
                chk(step_valid ? (delta != 0) : (delta == 0),
                    "delta_vs_valid", int'(delta), int'(step_valid));
                chk(!(done && err), "done_err_excl",
                    int'({done, err}), 0);
                if (hold)
                    chk(step_valid && delta == hd && direction == hdir,
                        "hold_stable", int'({step_valid, delta, direction}),
                        int'({1'b1, hd, hdir}));
                hold = step_valid && !step_ready;
                hd = delta;
                hdir = direction;
                if (step_valid && step_ready) begin
                    g = '{K_STEP, delta, direction};
                    expect_ev(g);
                end
                if (done) begin
                    g = '{K_DONE, 3'd0, 1'b0};
                    expect_ev(g);
                end
                if (err) begin
                    g = '{K_ERR, 3'd0, 1'b0};
                    expect_ev(g);
                end
            end
        end
    end

    task automatic start(input logic [3:0] t, input int mode);
        int n;
        n = 0;
        while (!tgt_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tgt_ready, "accept_ready", int'(tgt_ready), 1);
        cmode = mode;
        cur_t = t;
        tgt = t;
        tgt_valid = 1'b1;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        tgt = 4'($urandom);
        plan(current, t, mode);
    endtask

    task automatic finish_move();
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || !tgt_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 3000, "move_timeout", n, 3000);
        if (cmode == 0)
            chk(current == cur_t, "final_pos", int'(current), int'(cur_t));
    endtask

    initial begin
        int n, m;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk(!step_valid && delta == 0 && !direction && !busy,
            "reset_outputs", int'({step_valid, delta, direction, busy}), 0);
        chk(tgt_ready && !done && !err, "reset_flags",
            int'({tgt_ready, done, err}), 4);

        rmode = 2;
        current = 4'd3;
        start(4'd5, 0);
        finish_move();

        current = 4'd15;
        start(4'd0, 0);
        finish_move();

        rmode = 1;
        @(negedge clk);
        current = 4'd2;
        start(4'd10, 0);
        n = 0;
        while (!step_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            chk(step_valid && delta == 3'd7 && direction,
                "backpressure_hold",
                int'({step_valid, delta, direction}), 15);
        end
        rmode = 2;
        finish_move();

        rmode = 0;
        current = 4'd6;
        start(4'd6, 0);
        @(negedge clk);
        chk(!done && busy, "null_calc", int'({done, busy}), 1);
        @(negedge clk);
        chk(done && !step_valid && busy, "null_done",
            int'({done, step_valid, busy}), 5);
        finish_move();

        current = 4'd0;
        start(4'd13, 0);
        repeat (3) @(negedge clk);
        tgt = 4'd1;
        tgt_valid = 1'b1;
        chk(!tgt_ready && busy, "busy_reject",
            int'({tgt_ready, busy}), 1);
        @(negedge clk);
        tgt_valid = 1'b0;
        finish_move();

        rmode = 2;
        current = 4'd4;
        start(4'd12, 1);
        finish_move();
        chk(tgt_ready && !busy && current == 4'd4, "frozen_idle",
            int'({tgt_ready, busy}), 2);

        rmode = 0;
        repeat (40) begin
            m = ($urandom_range(0, 9) < 7) ? 0 :
                ($urandom_range(0, 1) != 0 ? 1 : 2);
            start(4'($urandom), m);
            finish_move();
        end

        rmode = 1;
        @(negedge clk);
        current = 4'd2;
        start(4'd10, 0);
        n = 0;
        while (!step_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(step_valid, "rst_pre_step", int'(step_valid), 1);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(!done && !err, "rst_no_pulse", int'({done, err}), 0);
        @(posedge clk);
        #1;
        q.delete();
        resetn = 1'b0;
        @(negedge clk);
        chk(!step_valid && delta == 0 && !busy && tgt_ready && !done,
            "rst_mid_step",
            int'({step_valid, delta, busy, tgt_ready, done}), 2);
        rmode = 0;
        start(4'd5, 0);
        finish_move();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/delta_planner.md
Name: delta_planner

Overview:
- Upstream stage of the ladder delta counter; turns a requested target position into a series of bounded step commands (delta, direction).
- Accepts one target per valid/ready handshake and compares it against the counter's fed-back current position.
- Issues steps of at most MAX_STEP until current equals the target, then pulses done.
- A step budget guards against a counter that never converges and ends the move with an error pulse.

Parameters:
- POS_W, 4, width of target and current position.
- STEP_W, 3, width of delta output.
- MAX_STEP, 7, largest delta issued per step; must be ≤ 2^STEP_W−1.
- SETTLE, 2, idle cycles after each accepted step before current is re-sampled (≥1).
- STEP_LIMIT, 15, maximum steps per move before abort.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- resetn  in  1  synchronous reset, active-high (1 = reset), sampled on clk rising edge.
- tgt_valid  in  1  target request valid.
- tgt_ready  out  1  planner can accept a target.
- tgt  in  POS_W  requested target position.
- current  in  POS_W  current position fed back from the delta counter.
- step_valid  out  1  delta/direction hold a step command.
- step_ready  in  1  delta counter accepts the step.
- delta  out  STEP_W  step magnitude; 0 whenever step_valid=0.
- direction  out  1  1 = up (target > current), 0 = down.
- busy  out  1  a move is in progress.
- done  out  1  one-cycle pulse when current == target.
- err  out  1  one-cycle pulse when STEP_LIMIT is exhausted.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on resetn.
- Reset values: FSM=IDLE, tgt_q=0, step_cnt=0, settle_cnt=0, step_valid=0, delta=0, direction=0, busy=0, done=0, err=0.
- Reset during any state aborts the move; no done or err pulse is produced.
- FSM states: IDLE, CALC, STEP, SETTLE, FIN.
- IDLE:
  - tgt_ready=1, busy=0.
  - On tgt_valid&&tgt_ready: latch tgt into tgt_q, clear step_cnt, go to CALC next cycle.
- CALC (1 cycle, busy=1, tgt_ready=0):
  - Sample current; diff = |tgt_q − current| computed at POS_W+1 bits, no wrap.
  - diff==0 → FIN with done.
  - Otherwise, if step_cnt==STEP_LIMIT → FIN with err.
  - Otherwise, register delta=min(diff,MAX_STEP), direction=(tgt_q>current), step_valid=1, go to STEP.
- STEP:
  - Hold delta, direction and step_valid stable until step_ready=1.
  - On the handshake cycle, the next cycle has step_valid=0 and delta=0; direction keeps its last value. step_cnt increments and settle_cnt loads SETTLE. Go to SETTLE.
- SETTLE:
  - Decrement settle_cnt each cycle; when it reaches 1, go to CALC.
  - Latency from step handshake to the next CALC is exactly SETTLE cycles.
- FIN (1 cycle):
  - Assert exactly one of done or err for this cycle, busy=1, then go to IDLE.
- Handshake rules:
  - tgt_valid while busy is ignored; tgt_ready=0 in every state except IDLE.
  - tgt is sampled only in the accepting cycle.
- Target equals current at acceptance: done is asserted 2 cycles after the accept edge, no step is issued, and step_cnt stays 0.
- Zero-delta steps are never emitted.
- A direction reversal (overshoot by the counter) is handled naturally: CALC recomputes each step.
- Back-to-back moves: a new target can be accepted in the cycle after FIN.
- All outputs are registered; no combinational path from inputs to outputs except tgt_ready, which is decoded from the state.

Test Plan:
- Reset check: assert resetn=1 for 2 cycles mid-STEP with step_valid=1 → next cycle step_valid=0, delta=0, busy=0, tgt_ready=1, no done pulse.
- Single-step move, upward: current=3, tgt=5, step_ready=1 tied → one step delta=2, direction=1. Model the counter: current becomes 5 before SETTLE expires. Result: done pulses once, total steps 1.
- Multi-step move, downward: current=15, tgt=0, model counter applies each delta → deltas 7,7,1 all with direction=0, then done. step_valid never asserts with delta=0.
- Backpressure: tgt=10 from current=2, hold step_ready=0 for 5 cycles → delta=7 and direction=1 stay stable and step_valid stays 1 throughout. Release step_ready → one handshake only.
- Null move and busy rejection:
  - tgt=current=6 → done 2 cycles after accept, step_valid never asserts.
  - During a move, pulse tgt_valid with tgt=1 → ignored; the move completes to the original target.
- Non-converging counter: current frozen at 4, tgt=12 → 15 steps of delta=7, direction=1 are accepted, then err pulses once. done stays 0 and the planner returns to IDLE.
